// File: rtl/prog_checker_pkg.sv
// Shared types and defaults for the program checker.
// Optional feature macro: PROG_CHECKER_FAIL_CAPTURE_EN (see prog_checker.sv).
package prog_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int          DEF_WIDTH      = 64;
  localparam int          DEF_NUM_CHECKS = 4;
  localparam int          DEF_IDX_W      = 4;
  localparam int          DEF_WDOG_W     = 16;
  localparam logic [15:0] DEF_WDOG_LIMIT = 16'h00FF;

  // Population count of up to 16 pass bits; used by scoreboards.
  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/prog_checker_wdog.sv
// Cycle watchdog: counts while enabled, clears on request, flags when the
// count equals LIMIT. Standalone so other bench top-levels can reuse it.
module prog_checker_wdog #(
  parameter int                WDOG_W = 16,
  parameter logic [WDOG_W-1:0] LIMIT  = '1
) (
  input  logic CLK,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WDOG_W-1:0] count;
  localparam logic [WDOG_W-1:0] ONE = WDOG_W'(1);

  // Counter: clear has priority over enable.
  always_ff @(posedge CLK) begin
    if (reset)    count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + ONE;
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/prog_checker.sv
// Program checker: walks a loadable table of (PC threshold, expected result)
// checkpoints while a CPU runs, one checkpoint per cycle at most, under a
// cycle watchdog. Reports per-check pass bits, a pass count and all-pass.
// Define PROG_CHECKER_FAIL_CAPTURE_EN to add first-mismatch capture outputs.
module prog_checker
  import prog_checker_pkg::*;
#(
  parameter int                WIDTH      = DEF_WIDTH,
  parameter int                NUM_CHECKS = DEF_NUM_CHECKS,
  parameter int                IDX_W      = DEF_IDX_W,
  parameter int                WDOG_W     = DEF_WDOG_W,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(DEF_WDOG_LIMIT)
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      currentpc,
  input  logic [WIDTH-1:0]      result,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [WIDTH-1:0]      cfg_pc,
  input  logic [WIDTH-1:0]      cfg_expected,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [NUM_CHECKS-1:0] pass_vec,
  output logic [IDX_W:0]        pass_count,
  output logic                  all_pass,
  output logic [IDX_W-1:0]      cur_check
`ifdef PROG_CHECKER_FAIL_CAPTURE_EN
  ,
  output logic                  fail_valid,
  output logic [IDX_W-1:0]      fail_idx,
  output logic [WIDTH-1:0]      fail_actual,
  output logic [WIDTH-1:0]      fail_pc
`endif
);

  // Table select width: just enough bits to address NUM_CHECKS entries.
  localparam int CK_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam logic [IDX_W:0]   NCHK     = (IDX_W+1)'(NUM_CHECKS);
  localparam logic [IDX_W-1:0] LAST     = IDX_W'(NUM_CHECKS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);

  state_t state;

  logic [WIDTH-1:0] table_pc  [NUM_CHECKS];
  logic [WIDTH-1:0] table_exp [NUM_CHECKS];

  logic [CK_W-1:0] cur_sel;
  logic [CK_W-1:0] cfg_sel;
  logic            cfg_ok;
  logic            start_go;
  logic            hit;
  logic            match;
  logic            last;
  logic            wd_expired;

  assign cur_sel  = cur_check[CK_W-1:0];
  assign cfg_sel  = cfg_idx[CK_W-1:0];
  // Table writes only outside a run and only to existing entries.
  assign cfg_ok   = cfg_we && (state != ST_RUN) && ({1'b0, cfg_idx} < NCHK);
  assign start_go = start && (state != ST_RUN);
  assign hit      = (state == ST_RUN) && (currentpc >= table_pc[cur_sel]);
  assign match    = (result == table_exp[cur_sel]);
  assign last     = (cur_check == LAST);

  prog_checker_wdog #(
    .WDOG_W (WDOG_W),
    .LIMIT  (WDOG_LIMIT)
  ) u_wdog (
    .CLK     (CLK),
    .reset   (reset),
    .clr     (start_go),
    .en      (state == ST_RUN),
    .expired (wd_expired)
  );

  // Checkpoint table: deliberately not reset so a reset keeps the program list.
  always_ff @(posedge CLK) begin
    if (cfg_ok) begin
      table_pc[cfg_sel]  <= cfg_pc;
      table_exp[cfg_sel] <= cfg_expected;
    end
  end

  // Run control FSM with registered status outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      pass_vec   <= '0;
      pass_count <= '0;
      cur_check  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
            timeout    <= 1'b0;
            pass_vec   <= '0;
            pass_count <= '0;
            cur_check  <= '0;
          end
        end
        ST_RUN: begin
          // A checkpoint reached this cycle is always scored, even on expiry.
          if (hit) begin
            pass_vec[cur_sel] <= match;
            if (match) pass_count <= pass_count + CNT_ONE;
            if (!last) cur_check <= cur_check + IDX_ONE;
          end
          // Watchdog expiry outranks a normal completion in the same cycle.
          if (wd_expired) begin
            timeout <= 1'b1;
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (hit && last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign all_pass = done && !timeout && (pass_count == NCHK);

`ifdef PROG_CHECKER_FAIL_CAPTURE_EN
  // First mismatching checkpoint of a run; frozen until the next run/reset.
  always_ff @(posedge CLK) begin
    if (reset || start_go) begin
      fail_valid  <= 1'b0;
      fail_idx    <= '0;
      fail_actual <= '0;
      fail_pc     <= '0;
    end else if (hit && !match && !fail_valid) begin
      fail_valid  <= 1'b1;
      fail_idx    <= cur_check;
      fail_actual <= result;
      fail_pc     <= currentpc;
    end
  end
`endif

endmodule

// File: tb/tb_prog_checker.sv
// Directed bench for prog_checker with NUM_CHECKS=2 and the default watchdog.
// Also checks pass_count against popcount(pass_vec) every cycle.
module tb_prog_checker;
  import prog_checker_pkg::*;

  localparam int WIDTH = 64;
  localparam int NCK   = 2;
  localparam int IDX_W = 4;
  localparam logic [63:0] BIG = 64'h1234_5678_9ABC_DEF0;

  logic             CLK = 1'b0;
  logic             reset, start, cfg_we;
  logic [WIDTH-1:0] currentpc, result, cfg_pc, cfg_expected;
  logic [IDX_W-1:0] cfg_idx;
  logic             busy, done, timeout, all_pass;
  logic [NCK-1:0]   pass_vec;
  logic [IDX_W:0]   pass_count;
  logic [IDX_W-1:0] cur_check;
`ifdef PROG_CHECKER_FAIL_CAPTURE_EN
  logic             fail_valid;
  logic [IDX_W-1:0] fail_idx;
  logic [WIDTH-1:0] fail_actual, fail_pc;
`endif

  int checks = 0;
  int errors = 0;

  prog_checker #(
    .WIDTH(WIDTH), .NUM_CHECKS(NCK), .IDX_W(IDX_W),
    .WDOG_W(16), .WDOG_LIMIT(16'h00FF)
  ) dut (
    .CLK(CLK), .reset(reset), .start(start),
    .currentpc(currentpc), .result(result),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc), .cfg_expected(cfg_expected),
    .busy(busy), .done(done), .timeout(timeout),
    .pass_vec(pass_vec), .pass_count(pass_count), .all_pass(all_pass),
    .cur_check(cur_check)
`ifdef PROG_CHECKER_FAIL_CAPTURE_EN
    , .fail_valid(fail_valid), .fail_idx(fail_idx),
    .fail_actual(fail_actual), .fail_pc(fail_pc)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input int idx, input logic [63:0] pc, input logic [63:0] ex);
    cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_pc = pc; cfg_expected = ex;
    tick();
    cfg_we = 1'b0;
  endtask

  // PC 0x0..0x54 step 4; result r30 at 0x30, BIG at 0x54, else 0.
  // meddle: at PC 0x8 try a table write and a restart while busy.
  task automatic run_seq(input logic [63:0] r30, input bit meddle);
    start = 1'b1; tick(); start = 1'b0;
    for (int pc = 0; pc <= 'h54; pc += 4) begin
      currentpc = 64'(pc);
      result    = (pc == 'h30) ? r30 : (pc == 'h54) ? BIG : 64'h0;
      if (meddle && pc == 8) begin
        cfg_we = 1'b1; cfg_idx = '0; cfg_pc = '0; cfg_expected = '0; start = 1'b1;
      end
      tick();
      cfg_we = 1'b0; start = 1'b0;
      if (pc == 'h2C) begin
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_cur", 64'(cur_check), 64'd0);
        chk("mid_pv", 64'(pass_vec), 64'd0);
      end
    end
  endtask

  task automatic end_chk(input string t, input logic [1:0] pv, input int pc_n, input bit ap);
    chk({t, "_done"}, 64'(done), 64'd1);
    chk({t, "_busy"}, 64'(busy), 64'd0);
    chk({t, "_to"}, 64'(timeout), 64'd0);
    chk({t, "_pv"}, 64'(pass_vec), 64'(pv));
    chk({t, "_cnt"}, 64'(pass_count), 64'(pc_n));
    chk({t, "_ap"}, 64'(all_pass), 64'(ap));
  endtask

  // pass_count must track popcount(pass_vec) on every cycle.
  always @(negedge CLK)
    if (!reset) chk("popcnt", 64'(pass_count), 64'(popcount(16'(pass_vec))));

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_pc = '0; cfg_expected = '0; currentpc = '0; result = '0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_to", 64'(timeout), 64'd0);
    chk("rst_pv", 64'(pass_vec), 64'd0);
    chk("rst_cnt", 64'(pass_count), 64'd0);
    chk("rst_cur", 64'(cur_check), 64'd0);
    reset = 1'b0;

    // 1: all checkpoints pass
    load(0, 64'h30, 64'hF);
    load(1, 64'h54, BIG);
    run_seq(64'hF, 1'b0);
    end_chk("t1", 2'b11, 2, 1'b1);

    // 2: entry0 mismatch
    run_seq(64'hE, 1'b0);
    end_chk("t2", 2'b10, 1, 1'b0);
`ifdef PROG_CHECKER_FAIL_CAPTURE_EN
    chk("t2_fv", 64'(fail_valid), 64'd1);
    chk("t2_fidx", 64'(fail_idx), 64'd0);
    chk("t2_fact", fail_actual, 64'hE);
    chk("t2_fpc", fail_pc, 64'h30);
`endif

    // 3: PC stuck -> watchdog
    currentpc = 64'h10; result = 64'h0;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!done && n < 400) begin tick(); n++; end
    chk("t3_cycles", 64'(n), 64'h100);
    chk("t3_to", 64'(timeout), 64'd1);
    chk("t3_pv", 64'(pass_vec), 64'd0);
    chk("t3_ap", 64'(all_pass), 64'd0);

    // 4: PC jump satisfies both thresholds -> consecutive cycles
    currentpc = 64'h0; result = 64'hF;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("t4_to_cleared", 64'(timeout), 64'd0);
    currentpc = 64'h60;
    tick();
    chk("t4_cur1", 64'(cur_check), 64'd1);
    chk("t4_pv_n", 64'(pass_vec), 64'd1);
    chk("t4_done_n", 64'(done), 64'd0);
    tick();
    end_chk("t4", 2'b01, 1, 1'b0);
`ifdef PROG_CHECKER_FAIL_CAPTURE_EN
    chk("t4_fidx", 64'(fail_idx), 64'd1);
    chk("t4_fact", fail_actual, 64'hF);
    chk("t4_fpc", fail_pc, 64'h60);
`endif

    // 5: reset mid-run keeps the table
    currentpc = 64'h0; result = 64'h0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    currentpc = 64'h4; tick();
    currentpc = 64'h30; result = 64'hF; tick();
    currentpc = 64'h34; result = 64'h0; tick();
    currentpc = 64'h38; tick();
    chk("t5_pv_pre", 64'(pass_vec), 64'd1);
    chk("t5_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_pv", 64'(pass_vec), 64'd0);
    chk("t5_cur", 64'(cur_check), 64'd0);
    run_seq(64'hF, 1'b0);
    end_chk("t5r", 2'b11, 2, 1'b1);

    // Out-of-range index write must not alias into the table
    load(3, 64'h0, 64'hDEAD);
    run_seq(64'hF, 1'b0);
    end_chk("oor", 2'b11, 2, 1'b1);

    // 6: cfg_we and start during RUN ignored
    run_seq(64'hF, 1'b1);
    end_chk("t6", 2'b11, 2, 1'b1);

    // done holds with no start
    tick(); tick();
    chk("hold_done", 64'(done), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_checker.md
Name: prog_checker

Overview:
- Synthesizable, parametrised successor to the single-program pass/fail harness around `singlecycle`.
- Watches `currentpc` and `MemtoRegOut` against a loadable table of NUM_CHECKS checkpoints, each a (PC threshold, expected value) pair.
- Enforces a cycle watchdog and reports per-check pass bits, a pass count and an all-pass flag.
- Sits beside the CPU in FPGA/sim top-levels so one regression covers N programs without per-program bench edits.

Parameters:
- WIDTH, 64, datapath width of PC, result and expected values
- NUM_CHECKS, 4, number of checkpoint entries (1..16)
- IDX_W, 4, width of checkpoint index (must satisfy 2**IDX_W >= NUM_CHECKS)
- WDOG_W, 16, watchdog counter width
- WDOG_LIMIT, 16'h00FF, cycles in RUN before timeout

Ports:
- CLK  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run from checkpoint 0
- currentpc  in  WIDTH  CPU program counter
- result  in  WIDTH  CPU MemtoRegOut value
- cfg_we  in  1  checkpoint table write enable (honoured only in IDLE/DONE)
- cfg_idx  in  IDX_W  table entry to write
- cfg_pc  in  WIDTH  PC threshold for entry
- cfg_expected  in  WIDTH  expected result for entry
- busy  out  1  high in RUN
- done  out  1  high in DONE
- timeout  out  1  watchdog expired during last run
- pass_vec  out  NUM_CHECKS  bit i = checkpoint i passed
- pass_count  out  IDX_W+1  number of passed checkpoints
- all_pass  out  1  done & ~timeout & (pass_count == NUM_CHECKS)
- cur_check  out  IDX_W  checkpoint currently awaited

Behaviour:
- Reset: state=IDLE; busy=0, done=0, timeout=0, pass_vec=0, pass_count=0, cur_check=0, watchdog=0. The table is NOT cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --(last check evaluated | watchdog==WDOG_LIMIT)--> DONE.
  - DONE --start--> RUN.
  - reset returns to IDLE from any state, including mid-run.
- Entering RUN clears pass_vec, pass_count, timeout, watchdog and cur_check in the same edge.
- In RUN, each cycle, with unsigned compare:
  - If currentpc >= table_pc[cur_check], sample result the same cycle.
  - pass_vec[cur_check] <= (result == table_expected[cur_check]).
  - pass_count increments on match.
  - cur_check increments; at NUM_CHECKS-1 go to DONE instead.
  - One checkpoint evaluated per cycle max. If PC already satisfies several thresholds, they resolve on consecutive cycles.
- Watchdog increments every RUN cycle. When it equals WDOG_LIMIT and the threshold is not met that cycle: timeout<=1, DONE, unevaluated pass bits stay 0. If the threshold is met in the same cycle, the check is evaluated first and then timeout is taken; timeout wins over a normal completion.
- start while busy is ignored. start in DONE restarts.
- cfg_we while busy is ignored. cfg_idx >= NUM_CHECKS is ignored.
- pass_count is combinationally equivalent to popcount(pass_vec) but registered; both must agree every cycle.
- done holds until start or reset.

Optional Feature:
- Macro: PROG_CHECKER_FAIL_CAPTURE_EN.
- Defined: adds outputs fail_valid (1), fail_idx (IDX_W), fail_actual (WIDTH) and fail_pc (WIDTH). They latch on the first mismatching checkpoint of a run, clear on run start and reset, and hold for the rest of the run.
- Undefined: those ports and registers do not exist; all other behaviour is identical.

Decomposition:
- prog_checker_pkg holds:
  - state typedef (IDLE/RUN/DONE)
  - default WIDTH/NUM_CHECKS/WDOG constants
  - a popcount function used by the bench scoreboard
- Sub-module prog_checker_wdog: WDOG_W counter with clear, enable and expired output (== WDOG_LIMIT). It is reusable by other bench top-levels.

Test Plan:
1. Load entry0=(0x30, 0xF), entry1=(0x54, 0x123456789ABCDEF0), NUM_CHECKS=2; pulse start, drive PC 0x0..0x54 step 4 with correct results -> pass_vec=2'b11, pass_count=2, all_pass=1, timeout=0.
2. Same as 1 but result=0xE when PC=0x30 -> pass_vec=2'b10, pass_count=1, all_pass=0; with FAIL_CAPTURE_EN: fail_idx=0, fail_actual=0xE, fail_pc=0x30.
3. PC stuck at 0x10, WDOG_LIMIT=0xFF -> done asserts exactly 0x100 cycles after start, timeout=1, pass_vec=0, all_pass=0.
4. PC jumps 0x0 -> 0x60 with result 0xF held -> entry0 evaluated on cycle N, entry1 on N+1. Expect pass_vec=2'b01.
5. Assert reset at cycle 5 of a run -> next cycle busy=0, done=0, pass_vec=0; the table still holds the earlier entries (re-run of test 1 passes without reload).
6. cfg_we during RUN with entry0=(0x0, 0x0) -> ignored; start pulses while busy -> ignored; run result matches test 1.
